// File: rtl/silly_bist_pkg.sv
// silly_bist_pkg: shared types and constants for the sillyfunction self-test sequencer.
package silly_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } bist_state_t;

  // Number of input combinations of the three-input block under test.
  localparam int NUM_VEC = 8;
  localparam int VEC_W   = $clog2(NUM_VEC);

  // Golden truth table of y = ~b&~c | a&~b; bit i is y for {a,b,c} = i.
  localparam logic [NUM_VEC-1:0] SILLY_EXPECTED = 8'h31;

endpackage

// File: rtl/bist_hold_timer.sv
// bist_hold_timer: loadable down-counter timing how long each vector is held.
// Stops at zero and flags it; a load takes priority over a decrement.
module bist_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register: load, else decrement towards zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/silly_bist.sv
// silly_bist: self-test sequencer for the sillyfunction block.
// Walks {a,b,c} through 0..7, holds each vector HOLD_CYCLES cycles (must be >= 1),
// samples dut_y against EXPECTED and reports pass, fail_mask and err_count.
// Optional feature macro: SILLY_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module silly_bist
  import silly_bist_pkg::*;
#(
  parameter int                 HOLD_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXPECTED    = SILLY_EXPECTED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dut_y,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [3:0]         err_count
);

  localparam int               CNT_W     = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);

  bist_state_t      state_q;
  bist_state_t      state_d;
  logic [VEC_W-1:0] vec_q;
  logic [CNT_W-1:0] hold_count;
  logic             hold_zero;
  logic             start_run;
  logic             mismatch;
  logic             last_vec;

  // start is only honoured while no run is in progress.
  assign start_run = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch  = (dut_y != EXPECTED[vec_q]);
  assign last_vec  = (vec_q == LAST_VEC);

  // Hold timer: loaded at run start and on every SAMPLE, counts down during APPLY.
  bist_hold_timer #(
    .W(CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_run || (state_q == SAMPLE)),
    .load_val (HOLD_LOAD),
    .dec      (state_q == APPLY),
    .count    (hold_count),
    .zero     (hold_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = APPLY;
      end
      APPLY: begin
        if (hold_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
`ifdef SILLY_BIST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_d = DONE;
`else
        if (last_vec) state_d = DONE;
`endif
        else state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector index and result registers: cleared at run start, updated on the edge ending SAMPLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      fail_mask <= '0;
      err_count <= '0;
    end else if (start_run) begin
      vec_q     <= '0;
      fail_mask <= '0;
      err_count <= '0;
    end else if (state_q == SAMPLE) begin
      if (mismatch) begin
        fail_mask[vec_q] <= 1'b1;
        err_count        <= err_count + 4'd1;
      end
      if (state_d == APPLY) vec_q <= vec_q + 1'b1;
    end
  end

  // Output decode: purely from registered state, never from start or dut_y.
  always_comb begin
    {a, b, c} = vec_q;
    busy      = (state_q == APPLY) || (state_q == SAMPLE);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) && (err_count == 4'd0);
  end

endmodule

// File: doc/silly_bist.md
# silly_bist

Built-in self-test sequencer for the three-input `sillyfunction` logic block (y = ~b&~c | a&~b). It walks the DUT through all eight input combinations in ascending order and holds each vector for a programmable settle time. It then samples the DUT output against a golden truth table and reports pass/fail, a per-vector failure mask and an error count. It sits beside the DUT on the board top, with `pass`/`done` wired to `ledg`, and replaces the simulation-only `initial`/`assert` checking with synthesizable logic.

## Interface
- `HOLD_CYCLES`, 2: cycles each vector is driven before sampling; must be ≥1.
- `EXPECTED`, 8'h31: golden truth table; bit i = expected y for {a,b,c} = i.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request to run a test; honoured in IDLE or DONE only.
- `dut_y` in 1: DUT output under test.
- `a`, `b`, `c` out 1 each: DUT stimulus; {a,b,c} = vector index (a is MSB).
- `busy` out 1: high in APPLY/SAMPLE.
- `done` out 1: high in DONE, held until next `start` or reset.
- `pass` out 1: valid when `done`; equals `err_count == 0`.
- `fail_mask` out 8: bit i set if vector i mismatched.
- `err_count` out 4: number of mismatching vectors, 0..8.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: `start` loads vec=0 and hold counter=HOLD_CYCLES-1, clears `fail_mask`/`err_count`, and moves to APPLY.
- APPLY: drives {a,b,c}=vec and decrements the hold counter. At counter 0 → SAMPLE.
- SAMPLE: stimulus unchanged; compares `dut_y` with `EXPECTED[vec]`.
  - On mismatch: set `fail_mask[vec]`, increment `err_count`.
  - If vec==7 → DONE; else vec+1, reload counter → APPLY.
- DONE: stimulus holds vector 7. `start` restarts exactly as from IDLE.
- `start` during APPLY/SAMPLE is ignored; the run continues undisturbed.
- `err_count` never exceeds 8, so no saturation is needed and there is no wrap.
- Comparison is plain 2-state equality in hardware.
- Reset mid-run aborts immediately. All state returns to reset values and no partial result is retained.

## Timing
- Reset values:
  - State IDLE.
  - `a`=`b`=`c`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `fail_mask`=8'h00, `err_count`=0.
- All outputs are registered; none depends combinationally on `dut_y` or `start`.
- Stimulus for vector 0 appears the cycle after the edge that samples `start`.
- Each vector occupies HOLD_CYCLES+1 cycles (HOLD_CYCLES in APPLY, 1 in SAMPLE).
- `done` rises exactly 8·(HOLD_CYCLES+1) cycles after the `start`-sampling edge; that is 24 cycles for the default.
- `fail_mask`/`err_count` update on the edge ending SAMPLE. `pass` is valid in the same cycle `done` rises.
- `busy` and `done` are never high together.

## Configuration
- `SILLY_BIST_STOP_ON_FAIL_EN` defined: the first mismatch in SAMPLE records its bit and count, then goes straight to DONE. Later vectors are not applied, so `fail_mask` has at most one bit set and `err_count` ≤ 1.
- Undefined (default): all eight vectors always run, and every mismatch is recorded.

## Structure
- Package `silly_bist_pkg`:
  - state enum `bist_state_t` {IDLE, APPLY, SAMPLE, DONE};
  - `NUM_VEC`=8;
  - default `SILLY_EXPECTED`=8'h31.
- One sub-module, `bist_hold_timer`: loadable down-counter with a `zero` flag, sized $clog2(HOLD_CYCLES)+1.
- The DUT (`sillyfunction`) is instantiated at the board top, not inside this block.

## Test plan
- Correct DUT connected, HOLD_CYCLES=2, pulse `start` → `done` after 24 cycles; `pass`=1, `fail_mask`=8'h00, `err_count`=0; {a,b,c} sequence 0..7.
- `dut_y` tied 0 → `pass`=0, `fail_mask`=8'h31, `err_count`=3.
- `dut_y` tied 1 → `pass`=0, `fail_mask`=8'hCE, `err_count`=5.
- Pulse `start` again at cycle 10 of a run → ignored; `done` still at cycle 24 with unchanged results. Then `start` in DONE → `fail_mask` cleared, new run.
- Assert `rst_n`=0 asynchronously mid-APPLY of vector 4 → all outputs at reset values immediately. After release, a new `start` gives a full clean run.
- With `SILLY_BIST_STOP_ON_FAIL_EN` and `dut_y` tied 1 → DONE after vector 1 SAMPLE (cycle 6); `fail_mask`=8'h02, `err_count`=1, {a,b,c}=3'b001.
